kitt_trail_pwm: RTL and testbench
=================================

Name: kitt_trail_pwm

Overview:
- Downstream stage of the scanner core: consumes the 8-bit LED level bitmap and drives per-LED PWM outputs with an afterglow trail.
- Any LED seen lit jumps to full brightness, then fades one step per decay tick.
- The scan spot therefore leaves a fading tail, giving the classic KITT look on the PWM pins.

Parameters:
- N_LED, 8, number of LED channels.
- BR_W, 4, brightness width; BR_MAX = 2^BR_W-1 = 15.
- PWM_PRE, 39, prescaler terminal count; pwm_tick every PWM_PRE+1 clk (250 kHz at 10 MHz).
- DECAY_DIV, 49999, decay terminal count; decay_tick every DECAY_DIV+1 clk (5 ms at 10 MHz).

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  asynchronous reset, active-high.
- ena  in  1  1 = run; 0 = freeze and blank outputs.
- lv_in  in  N_LED  level bitmap from the scan core; bit i = LED i lit this cycle.
- oinv  in  1  output polarity invert.
- pwm_out  out  N_LED  registered PWM drive per LED.
- frame_tick  out  1  one-clk pulse at each PWM frame boundary.

Behaviour:
- Reset is asynchronous and active-high. It clears immediately, with no clock edge required:
  - prescaler, decay counter, pwm_cnt, bright[], duty_sh[] all go to 0;
  - pwm_out = 0 and frame_tick = 0, regardless of oinv.
- Prescaler: counts 0..PWM_PRE and wraps. pwm_tick = (presc == PWM_PRE) && ena.
- Decay counter: counts 0..DECAY_DIV and wraps. decay_tick = (dcnt == DECAY_DIV) && ena.
- pwm_cnt: BR_W bits, counts 0..BR_MAX-1 (15 steps per frame).
  - Advances on pwm_tick; wraps from BR_MAX-1 to 0.
  - Frame boundary = pwm_tick while pwm_cnt == BR_MAX-1.
- Brightness update per LED i, each clk while ena=1:
  - If lv_in[i] = 1: bright[i] <= BR_MAX.
  - Else if decay_tick and bright[i] > 0: bright[i] <= bright[i]-1.
  - Otherwise: hold.
  - lv_in beats a simultaneous decay_tick. bright[i] saturates at 0 and never wraps.
- Shadow: at the frame boundary edge, duty_sh[i] <= bright[i] (pre-edge value). Duty therefore changes only at frame starts, so there are no mid-frame glitches.
- Output: pwm_out[i] <= (duty_sh[i] > pwm_cnt) ^ oinv.
  - Duty is duty_sh/15: 0 gives always off, 15 gives always on.
  - Latency is 1 clk from pwm_cnt/duty_sh to pwm_out.
- frame_tick: registered, high for exactly the clk after each frame boundary edge.
- ena = 0:
  - all counters, bright[] and duty_sh[] hold;
  - pwm_out <= {N_LED{oinv}} (LEDs off), frame_tick = 0.
- On return of ena = 1, counting resumes from the held values; there is no restart.
- oinv toggling mid-frame takes effect on the next clk with no other side effect.
- End-to-end latency, lv_in rise to full duty on pwm_out: 1 clk into bright, up to one frame into duty_sh, then 1 clk.

Decomposition:
- Package kitt_pkg holds:
  - BR_W, BR_MAX;
  - default PWM_PRE and DECAY_DIV;
  - typedef bright_t (logic [BR_W-1:0]).
- Sub-module kitt_tick_div: parameterised modulo counter with enable, async active-high reset and a terminal-count tick output.
  - Instantiated twice, once as the prescaler and once as the decay divider.
- The per-LED bright/duty_sh/compare logic is a generate loop in the top.

Test Plan:
All cases use sim params PWM_PRE=0, DECAY_DIV=9, so the frame is 15 clk and decay is 1 step per 10 clk.
1. Reset: rst=1 with clk stopped -> pwm_out=8'h00 and frame_tick=0 at once. Release with lv_in=0, ena=1, oinv=0 -> pwm_out stays 8'h00; frame_tick pulses every 15 clk.
2. Static lit: lv_in=8'h81 held -> from the second frame onward pwm_out=8'h81 every clk (100% duty); other bits always 0.
3. Decay trail: one-clk pulse on lv_in[3], then 0 -> bright[3] goes 15,14,13... one step per 10 clk. High clk count of pwm_out[3] per frame equals the duty_sh latched at that frame start. pwm_out[3] stays 0 once bright[3] reaches 0; no underflow.
4. Priority: lv_in[5]=1 on the same clk as decay_tick -> bright[5] stays 15.
5. Polarity and enable:
   - oinv=1 with scenario 2 -> pwm_out=8'h7E.
   - Then ena=0 for 50 clk -> pwm_out=8'hFF, frame_tick=0, bright[] frozen.
   - ena=1 -> same duty pattern resumes with no lost decay steps.
6. Async reset mid-frame: assert rst between clk edges while pwm_out=8'h81 -> outputs are 0 before the next edge. After release, the first frame shows pwm_out=0 until the first boundary loads duty_sh.

Source files
------------

// File: rtl/kitt_pkg.sv
// rtl/kitt_pkg.sv - shared widths, defaults and types for the KITT trail PWM stage
package kitt_pkg;
   localparam int BR_W          = 4;
   localparam int BR_MAX        = (1 << BR_W) - 1;
   localparam int PWM_PRE_DEF   = 39;
   localparam int DECAY_DIV_DEF = 49999;

   typedef logic [BR_W-1:0] bright_t;
endpackage

// File: rtl/kitt_tick_div.sv
// rtl/kitt_tick_div.sv - enabled modulo counter emitting a tick at its terminal count
module kitt_tick_div #(
   parameter int TC = 39
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output logic tick
);
   localparam int W = (TC < 1) ? 1 : $clog2(TC + 1);
   localparam logic [W-1:0] TC_V = W'(TC);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (ena) begin
         cnt <= (cnt == TC_V) ? '0 : cnt + W'(1);
      end
   end

   assign tick = ena && (cnt == TC_V);
endmodule

// File: rtl/kitt_trail_pwm.sv
// rtl/kitt_trail_pwm.sv - per-LED afterglow brightness with frame-shadowed PWM outputs
module kitt_trail_pwm
   import kitt_pkg::*;
#(
   parameter int N_LED     = 8,
   parameter int PWM_PRE   = PWM_PRE_DEF,
   parameter int DECAY_DIV = DECAY_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [N_LED-1:0] lv_in,
   input  logic             oinv,
   output logic [N_LED-1:0] pwm_out,
   output logic             frame_tick
);
   localparam bright_t CNT_LAST = bright_t'(BR_MAX - 1);
   localparam bright_t BR_FULL  = bright_t'(BR_MAX);

   logic             pwm_tick;
   logic             decay_tick;
   logic             frame_edge;
   bright_t          pwm_cnt;
   logic [N_LED-1:0] pwm_nxt;

   kitt_tick_div #(.TC(PWM_PRE)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .tick (pwm_tick)
   );

   kitt_tick_div #(.TC(DECAY_DIV)) u_decay (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .tick (decay_tick)
   );

   // 15 steps per frame so that duty 15 is fully on and duty 0 fully off
   assign frame_edge = pwm_tick && (pwm_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else if (pwm_tick) begin
         pwm_cnt <= frame_edge ? '0 : pwm_cnt + bright_t'(1);
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_led
      bright_t bright;
      bright_t duty_sh;

      // duty_sh samples the pre-edge brightness so a frame never changes duty midway
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            bright  <= '0;
            duty_sh <= '0;
         end else if (ena) begin
            if (frame_edge) begin
               duty_sh <= bright;
            end
            if (lv_in[i]) begin
               bright <= BR_FULL;
            end else if (decay_tick && (bright != '0)) begin
               bright <= bright - bright_t'(1);
            end
         end
      end

      assign pwm_nxt[i] = ena ? ((duty_sh > pwm_cnt) ^ oinv) : oinv;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out    <= '0;
         frame_tick <= 1'b0;
      end else begin
         pwm_out    <= pwm_nxt;
         frame_tick <= frame_edge;
      end
   end
endmodule

// File: tb/tb_kitt_trail_pwm.sv
// tb/tb_kitt_trail_pwm.sv - self-checking bench for kitt_trail_pwm
module tb_kitt_trail_pwm;
   localparam int SIM_PRE = 0;
   localparam int SIM_DEC = 9;

   logic       clk;
   logic       clk_en;
   logic       rst;
   logic       ena;
   logic [7:0] lv_in;
   logic       oinv;
   logic [7:0] pwm_out;
   logic       frame_tick;

   kitt_trail_pwm #(
      .N_LED     (8),
      .PWM_PRE   (SIM_PRE),
      .DECAY_DIV (SIM_DEC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .lv_in      (lv_in),
      .oinv       (oinv),
      .pwm_out    (pwm_out),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   typedef struct {
      logic [7:0] lv;
      logic       ena;
      logic       oinv;
      int         cycles;
      logic [7:0] exp_last;
   } vec_t;

   typedef struct {
      logic [7:0] pwm;
      logic       ft;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   e     = 0;

   int m_presc, m_dcnt, m_pcnt;
   int m_br[8];
   int m_du[8];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
      end
   endtask

   task automatic model_reset();
      m_presc = 0;
      m_dcnt  = 0;
      m_pcnt  = 0;
      for (int i = 0; i < 8; i++) begin
         m_br[i] = 0;
         m_du[i] = 0;
      end
   endtask

   task automatic model_step(output logic [7:0] ep, output logic ef);
      logic pt, dt, fr;
      pt = ena && (m_presc == SIM_PRE);
      dt = ena && (m_dcnt == SIM_DEC);
      fr = pt && (m_pcnt == 14);
      for (int i = 0; i < 8; i++) begin
         ep[i] = ena ? ((m_du[i] > m_pcnt) ^ oinv) : oinv;
      end
      ef = fr;
      if (ena) begin
         m_presc = (m_presc == SIM_PRE) ? 0 : m_presc + 1;
         m_dcnt  = (m_dcnt == SIM_DEC) ? 0 : m_dcnt + 1;
         if (pt) m_pcnt = (m_pcnt == 14) ? 0 : m_pcnt + 1;
         for (int i = 0; i < 8; i++) begin
            if (fr) m_du[i] = m_br[i];
            if (lv_in[i]) m_br[i] = 15;
            else if (dt && m_br[i] > 0) m_br[i] = m_br[i] - 1;
         end
      end
   endtask

   task automatic step();
      exp_t x;
      model_step(x.pwm, x.ft);
      sb.push_back(x);
      @(posedge clk);
      #1;
      e++;
      x = sb.pop_front();
      check("sb_pwm", pwm_out, x.pwm);
      check("sb_frame_tick", {7'b0, frame_tick}, {7'b0, x.ft});
   endtask

   vec_t vt[6];
   int   ft_cnt;
   int   hc;
   int   ex;

   initial begin
      vt[0] = '{8'h00, 1'b1, 1'b0, 45, 8'h00};
      vt[1] = '{8'h81, 1'b1, 1'b0, 30, 8'h81};
      vt[2] = '{8'h81, 1'b1, 1'b1, 15, 8'h7E};
      vt[3] = '{8'h81, 1'b0, 1'b1, 50, 8'hFF};
      vt[4] = '{8'h81, 1'b1, 1'b1, 15, 8'h7E};
      vt[5] = '{8'h81, 1'b1, 1'b0,  7, 8'h81};

      clk_en = 1'b0;
      rst    = 1'b0;
      ena    = 1'b1;
      lv_in  = 8'h00;
      oinv   = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("reset_pwm", pwm_out, 8'h00);
      check("reset_frame_tick", {7'b0, frame_tick}, 8'h00);

      clk_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      e = 0;

      ft_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         lv_in = vt[k].lv;
         ena   = vt[k].ena;
         oinv  = vt[k].oinv;
         for (int c = 0; c < vt[k].cycles; c++) begin
            step();
            if (k == 0 && frame_tick) ft_cnt++;
            if (!vt[k].ena) check("disabled_frame_tick", {7'b0, frame_tick}, 8'h00);
         end
         check("phase_last_pwm", pwm_out, vt[k].exp_last);
      end
      check("idle_frame_ticks", ft_cnt[7:0], 8'd3);

      // asynchronous reset landing between clock edges
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_pwm", pwm_out, 8'h00);
      check("async_rst_frame_tick", {7'b0, frame_tick}, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      e = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         check("post_rst_first_frame", pwm_out, 8'h00);
      end
      step();
      check("post_rst_loaded", pwm_out, 8'h81);

      // fresh start for the decay trail
      lv_in = 8'h00;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      e = 0;
      lv_in = 8'h08;
      step();
      lv_in = 8'h00;
      while (e < 15) step();
      for (int k = 1; k <= 12; k++) begin
         hc = 0;
         for (int c = 0; c < 15; c++) begin
            step();
            if (pwm_out[3]) hc++;
         end
         ex = 15 - (15 * k - 1) / 10;
         if (ex < 0) ex = 0;
         check("decay_frame_high", hc[7:0], ex[7:0]);
      end

      // lv_in[5] coincides with a decay tick at edge 220
      while (e < 219) step();
      lv_in = 8'h20;
      step();
      lv_in = 8'h00;
      while (e < 225) step();
      hc = 0;
      for (int c = 0; c < 15; c++) begin
         step();
         if (pwm_out[5]) hc++;
      end
      check("priority_frame_high", hc[7:0], 8'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
